// File: rtl/cpu_checker_pkg.sv
// Shared definitions for the CPU trace-line checker: parse states, format codes,
// error-bit positions, grammar characters and the word range helpers.
package cpu_checker_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    TIME = 4'd1,
    PC   = 4'd2,
    SP1  = 4'd3,
    GRF  = 4'd4,
    ADDR = 4'd5,
    SP2  = 4'd6,
    LT   = 4'd7,
    SP3  = 4'd8,
    DATA = 4'd9,
    SP4  = 4'd10,
    DONE = 4'd11
  } state_t;

  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_REG  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  localparam int ERR_TIME = 0;
  localparam int ERR_PC   = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_GRF  = 3;

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;

  // Borrow-out of 33-bit differences avoids degenerate compares when a bound is zero.
  function automatic logic outside_range(input logic [31:0] v, input logic [31:0] lo,
                                         input logic [31:0] hi);
    logic [32:0] below;
    logic [32:0] above;
    below = {1'b0, v} - {1'b0, lo};
    above = {1'b0, hi} - {1'b0, v};
    return below[32] | above[32];
  endfunction

  function automatic logic word_bad(input logic [31:0] v, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (v[1:0] != 2'b00) | outside_range(v, lo, hi);
  endfunction

endpackage

// File: rtl/cpu_checker_pro_char_class.sv
// Combinational ASCII classifier: decimal digit, lowercase hex digit, and nibble value.
module char_class (
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex_lc,
  output logic [3:0] hex_val
);

  // Classify one character; uppercase A-F is deliberately not hex here.
  always_comb begin
    is_dec    = 1'b0;
    is_hex_lc = 1'b0;
    hex_val   = 4'h0;
    if ((char >= 8'h30) && (char <= 8'h39)) begin
      is_dec    = 1'b1;
      is_hex_lc = 1'b1;
      hex_val   = char[3:0];
    end else if ((char >= 8'h61) && (char <= 8'h66)) begin
      is_hex_lc = 1'b1;
      hex_val   = char[3:0] + 4'd9;
    end else begin
      is_dec    = 1'b0;
      is_hex_lc = 1'b0;
      hex_val   = 4'h0;
    end
  end

endmodule

// File: rtl/cpu_checker_pro.sv
// Streaming checker for CPU register/memory write trace lines, one character per cycle;
// reports format and address/time/register errors for one cycle after the closing '#'.
module cpu_checker_pro
  import cpu_checker_pkg::*;
#(
  parameter int          TIME_DIGITS_MAX = 4,
  parameter int          GRF_DIGITS_MAX  = 4,
  parameter int          FREQ_W          = 16,
  parameter logic [31:0] PC_LO           = 32'h0000_3000,
  parameter logic [31:0] PC_HI           = 32'h0000_6ffc,
  parameter logic [31:0] ADDR_LO         = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI         = 32'h0000_2ffc
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  input  logic [FREQ_W-1:0] freq,
  output logic [1:0]        format_type,
  output logic [3:0]        error_code
);

  localparam int TIME_W  = $clog2(10 ** TIME_DIGITS_MAX);
  localparam int GRF_W   = $clog2(10 ** GRF_DIGITS_MAX);
  localparam int CNT_TOP = (TIME_DIGITS_MAX > GRF_DIGITS_MAX)
                         ? ((TIME_DIGITS_MAX > 8) ? TIME_DIGITS_MAX : 8)
                         : ((GRF_DIGITS_MAX > 8) ? GRF_DIGITS_MAX : 8);
  localparam int CNT_W   = $clog2(CNT_TOP + 2);
  localparam int CMP_W   = (TIME_W > FREQ_W) ? TIME_W : FREQ_W;

  localparam logic [CNT_W-1:0] TIME_CNT_MAX = CNT_W'(TIME_DIGITS_MAX);
  localparam logic [CNT_W-1:0] GRF_CNT_MAX  = CNT_W'(GRF_DIGITS_MAX);
  localparam logic [CNT_W-1:0] HEX_CNT      = CNT_W'(4'd8);
  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_SAT      = '1;

  state_t            state;
  state_t            state_nx;
  logic [TIME_W-1:0] time_acc;
  logic [TIME_W-1:0] time_nx;
  logic [GRF_W-1:0]  grf_acc;
  logic [GRF_W-1:0]  grf_nx;
  logic [31:0]       hex_acc;
  logic [31:0]       hex_nx;
  logic [31:0]       pc_val;
  logic [31:0]       pc_nx;
  logic [31:0]       addr_val;
  logic [31:0]       addr_nx;
  logic [1:0]        fmt;
  logic [1:0]        fmt_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic [CNT_W-1:0]  cnt_inc;

  logic              is_dec;
  logic              is_hex_lc;
  logic [3:0]        hex_val;
  logic              time_cnt_ok;
  logic              grf_cnt_ok;
  logic              hex_cnt_ok;
  logic [CMP_W-1:0]  time_ext;
  logic [CMP_W-1:0]  mask_ext;

  char_class u_char_class (
    .char      (char),
    .is_dec    (is_dec),
    .is_hex_lc (is_hex_lc),
    .hex_val   (hex_val)
  );

  // The digit counter saturates so an over-long field is still caught at its terminator.
  assign cnt_inc     = (cnt == CNT_SAT) ? cnt : (cnt + CNT_ONE);
  assign time_cnt_ok = (cnt != CNT_ZERO) && (cnt <= TIME_CNT_MAX);
  assign grf_cnt_ok  = (cnt != CNT_ZERO) && (cnt <= GRF_CNT_MAX);
  assign hex_cnt_ok  = (cnt == HEX_CNT);
  assign time_ext    = CMP_W'(time_acc);
  assign mask_ext    = CMP_W'((freq >> 1) - FREQ_W'(1'b1));

  // Next-state and next-datapath logic: one grammar step per character.
  always_comb begin
    state_nx = IDLE;
    time_nx  = time_acc;
    grf_nx   = grf_acc;
    hex_nx   = hex_acc;
    pc_nx    = pc_val;
    addr_nx  = addr_val;
    fmt_nx   = fmt;
    cnt_nx   = cnt;
    if (char == CH_CARET) begin
      state_nx = TIME;
      time_nx  = '0;
      grf_nx   = '0;
      hex_nx   = 32'h0000_0000;
      pc_nx    = 32'h0000_0000;
      addr_nx  = 32'h0000_0000;
      fmt_nx   = FMT_NONE;
      cnt_nx   = CNT_ZERO;
    end else begin
      case (state)
        IDLE: state_nx = IDLE;
        TIME: begin
          if (is_dec) begin
            state_nx = TIME;
            time_nx  = TIME_W'(time_acc * TIME_W'(4'd10) + TIME_W'(hex_val));
            cnt_nx   = cnt_inc;
          end else if ((char == CH_AT) && time_cnt_ok) begin
            state_nx = PC;
            cnt_nx   = CNT_ZERO;
          end else begin
            state_nx = IDLE;
          end
        end
        PC: begin
          if (is_hex_lc) begin
            state_nx = PC;
            hex_nx   = {hex_acc[27:0], hex_val};
            cnt_nx   = cnt_inc;
          end else if ((char == CH_COLON) && hex_cnt_ok) begin
            state_nx = SP1;
            pc_nx    = hex_acc;
          end else begin
            state_nx = IDLE;
          end
        end
        SP1: begin
          if (char == CH_SP) begin
            state_nx = SP1;
          end else if (char == CH_DOLLAR) begin
            state_nx = GRF;
            fmt_nx   = FMT_REG;
            cnt_nx   = CNT_ZERO;
          end else if (char == CH_STAR) begin
            state_nx = ADDR;
            fmt_nx   = FMT_MEM;
            cnt_nx   = CNT_ZERO;
          end else begin
            state_nx = IDLE;
          end
        end
        GRF: begin
          if (is_dec) begin
            state_nx = GRF;
            grf_nx   = GRF_W'(grf_acc * GRF_W'(4'd10) + GRF_W'(hex_val));
            cnt_nx   = cnt_inc;
          end else if ((char == CH_SP) && grf_cnt_ok) begin
            state_nx = SP2;
          end else if ((char == CH_LT) && grf_cnt_ok) begin
            state_nx = LT;
          end else begin
            state_nx = IDLE;
          end
        end
        ADDR: begin
          if (is_hex_lc) begin
            state_nx = ADDR;
            hex_nx   = {hex_acc[27:0], hex_val};
            cnt_nx   = cnt_inc;
          end else if ((char == CH_SP) && hex_cnt_ok) begin
            state_nx = SP2;
            addr_nx  = hex_acc;
          end else if ((char == CH_LT) && hex_cnt_ok) begin
            state_nx = LT;
            addr_nx  = hex_acc;
          end else begin
            state_nx = IDLE;
          end
        end
        SP2: begin
          if (char == CH_SP) begin
            state_nx = SP2;
          end else if (char == CH_LT) begin
            state_nx = LT;
          end else begin
            state_nx = IDLE;
          end
        end
        LT: begin
          if (char == CH_EQ) begin
            state_nx = SP3;
            cnt_nx   = CNT_ZERO;
          end else begin
            state_nx = IDLE;
          end
        end
        SP3: begin
          if (char == CH_SP) begin
            state_nx = SP3;
          end else if (is_hex_lc) begin
            state_nx = DATA;
            hex_nx   = {hex_acc[27:0], hex_val};
            cnt_nx   = CNT_ONE;
          end else begin
            state_nx = IDLE;
          end
        end
        DATA: begin
          if (is_hex_lc) begin
            state_nx = DATA;
            hex_nx   = {hex_acc[27:0], hex_val};
            cnt_nx   = cnt_inc;
          end else if ((char == CH_SP) && hex_cnt_ok) begin
            state_nx = SP4;
          end else if ((char == CH_HASH) && hex_cnt_ok) begin
            state_nx = DONE;
          end else begin
            state_nx = IDLE;
          end
        end
        SP4: begin
          if (char == CH_SP) begin
            state_nx = SP4;
          end else if (char == CH_HASH) begin
            state_nx = DONE;
          end else begin
            state_nx = IDLE;
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      time_acc <= '0;
      grf_acc  <= '0;
      hex_acc  <= 32'h0000_0000;
      pc_val   <= 32'h0000_0000;
      addr_val <= 32'h0000_0000;
      fmt      <= FMT_NONE;
      cnt      <= CNT_ZERO;
    end else begin
      state    <= state_nx;
      time_acc <= time_nx;
      grf_acc  <= grf_nx;
      hex_acc  <= hex_nx;
      pc_val   <= pc_nx;
      addr_val <= addr_nx;
      fmt      <= fmt_nx;
      cnt      <= cnt_nx;
    end
  end

  // Verdict is decoded from the registered record while in DONE only.
  always_comb begin
    format_type = FMT_NONE;
    error_code  = 4'b0000;
    if (state == DONE) begin
      format_type          = fmt;
      error_code[ERR_TIME] = |(time_ext & mask_ext);
      error_code[ERR_PC]   = word_bad(pc_val, PC_LO, PC_HI);
      error_code[ERR_ADDR] = (fmt == FMT_MEM) && word_bad(addr_val, ADDR_LO, ADDR_HI);
      error_code[ERR_GRF]  = (fmt == FMT_REG) && (32'(grf_acc) > 32'd31);
    end else begin
      format_type = FMT_NONE;
      error_code  = 4'b0000;
    end
  end

endmodule

// File: tb/tb_cpu_checker_pro.sv
// Directed bench for cpu_checker_pro: feeds trace lines and checks the one-cycle verdict.
module tb_cpu_checker_pro;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char;
  logic [15:0] freq;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  cpu_checker_pro dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .freq        (freq),
    .format_type (format_type),
    .error_code  (error_code)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [7:0] c);
    char = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input string s);
    for (int i = 0; i < s.len(); i++) tick(s[i]);
  endtask

  // Sends one line, requires silence before its last character, the verdict right
  // after it, and silence again one cycle later.
  task automatic send_rec(input string tag, input string s, input logic [1:0] exp_fmt,
                          input logic [3:0] exp_err);
    logic early;
    early = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      tick(s[i]);
      if ((i < s.len() - 1) && ((format_type != 2'd0) || (error_code != 4'd0))) early = 1'b1;
    end
    check_eq({tag, "/early"}, {7'd0, early}, 8'd0);
    check_eq({tag, "/fmt"}, {6'd0, format_type}, {6'd0, exp_fmt});
    check_eq({tag, "/err"}, {4'd0, error_code}, {4'd0, exp_err});
    tick(8'h0a);
    check_eq({tag, "/clr"}, {2'd0, format_type, error_code}, 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    char  = 8'h00;
    freq  = 16'd2;
    tick(8'h00);
    tick(8'h00);
    check_eq("reset", {2'd0, format_type, error_code}, 8'd0);
    reset = 1'b0;

    send_rec("reg_ok",  "^242@000030f4: $31 <= 12345678#", 2'd1, 4'b0000);
    send_rec("mem_ok",  "^338@00003130: *00000088 <= ffffb528#", 2'd2, 4'b0000);
    send_rec("data_uc", "^338@00003130: *00000088 <= Ffffb528#", 2'd0, 4'b0000);
    send_rec("data6",   "^242@000030f4: $31 <= 123456#", 2'd0, 4'b0000);
    send_rec("data10",  "^242@000030f4: $31 <= 1234567890#", 2'd0, 4'b0000);
    send_rec("data0",   "^242@000030f4: $31 <=#", 2'd0, 4'b0000);
    send_rec("pc_uc",   "^242@000030F4: $31 <= 12345678#", 2'd0, 4'b0000);
    send_rec("time0",   "^@000030f4: $31 <= 12345678#", 2'd0, 4'b0000);
    send_rec("time5",   "^12345@000030f4: $31 <= 12345678#", 2'd0, 4'b0000);
    send_rec("grf5",    "^242@000030f4: $00031 <= 12345678#", 2'd0, 4'b0000);
    send_rec("grf0",    "^242@000030f4: $ <= 12345678#", 2'd0, 4'b0000);
    send_rec("tab",     "^242@000030f4:\t$31 <= 12345678#", 2'd0, 4'b0000);
    send_rec("nosp",    "^242@000030f4:$31<=12345678 #", 2'd1, 4'b0000);
    send_rec("pc_hi",   "^1@00006ffc: $0 <= 00000000#", 2'd1, 4'b0000);
    send_rec("pc_ovr",  "^1@00007000: $0 <= 00000000#", 2'd1, 4'b0010);
    send_rec("pc_low",  "^1@00002ffc: $0 <= 00000000#", 2'd1, 4'b0010);
    send_rec("addr_hi", "^1@00003000: *00002ffc <= 00000000#", 2'd2, 4'b0000);
    send_rec("addr_ov", "^1@00003000: *00003000 <= 00000000#", 2'd2, 4'b0100);

    freq = 16'd4;
    send_rec("t_err",   "^243@00003130: $5 <= 00000000#", 2'd1, 4'b0001);
    send_rec("t_lead",  "^0242@00003130: $0031 <= 00000000#", 2'd1, 4'b0000);
    send_rec("pc_mis",  "^242@00003132: $5 <= 00000000#", 2'd1, 4'b0010);
    send_rec("a_mis",   "^242@00003130: *00000089 <= 00000000#", 2'd2, 4'b0100);
    send_rec("grf32",   "^242@00003130: $32 <= 00000000#", 2'd1, 4'b1000);
    send_rec("multi",   "^243@00002000: $32<=00000000#", 2'd1, 4'b1011);
    freq = 16'd16;
    send_rec("t_f16",   "^12@00003000: $1 <= 00000000#", 2'd1, 4'b0001);

    freq = 16'd2;
    send_rec("restart", "^242@0000^338@00003130: $1<=00000000#", 2'd1, 4'b0000);

    send_raw("^242@000030f4: $31 <= 12345678#");
    check_eq("b2b_first", {2'd0, format_type, error_code}, 8'h10);
    send_rec("b2b",     "^338@00003130: *00000088 <= ffffb528#", 2'd2, 4'b0000);

    send_raw("^242@00003130: $5 <= 1234");
    reset = 1'b1;
    tick(8'h23);
    check_eq("rst_mid", {2'd0, format_type, error_code}, 8'd0);
    reset = 1'b0;
    tick(8'h23);
    check_eq("rst_after", {2'd0, format_type, error_code}, 8'd0);
    send_rec("post_rst", "^242@000030f4: $31 <= 12345678#", 2'd1, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_checker_pro.md
CPU_CHECKER_PRO -- requirements
Module: cpu_checker_pro

Interface
REQ-001 SHALL have parameter TIME_DIGITS_MAX, default 4: maximum decimal digits of the time field.
REQ-002 SHALL have parameter GRF_DIGITS_MAX, default 4: maximum decimal digits of the register field.
REQ-003 SHALL have parameter FREQ_W, default 16: width of the freq input.
REQ-004 SHALL have parameters PC_LO/PC_HI, defaults 32'h0000_3000/32'h0000_6ffc: legal PC range, inclusive.
REQ-005 SHALL have parameters ADDR_LO/ADDR_HI, defaults 32'h0000_0000/32'h0000_2ffc: legal memory address range, inclusive.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 char  input  8  ASCII character, one per cycle.
REQ-009 freq  input  FREQ_W  clock frequency; even power of two, >=2; stable during a record.
REQ-010 format_type  output  2  0 = none/invalid, 1 = register write, 2 = memory write.
REQ-011 error_code  output  4  bit0 time, bit1 pc, bit2 addr, bit3 grf; valid only when format_type!=0.

Function
REQ-012 Grammar, format 1: '^' TIME '@' PC ':' SP* '$' GRF SP* "<=" SP* DATA SP* '#'.
REQ-013 Grammar, format 2: the same as format 1, with '*' ADDR in place of '$' GRF.
REQ-014 Field widths: TIME is 1..TIME_DIGITS_MAX digits 0-9; GRF is 1..GRF_DIGITS_MAX digits 0-9.
REQ-015 Field widths: PC, ADDR and DATA are exactly 8 hex digits, from 0-9 and lowercase a-f only; uppercase is illegal.
REQ-016 SP SHALL be ASCII space (0x20) only.
REQ-017 FSM states: IDLE, TIME, PC, SP1, GRF, ADDR, SP2, LT, SP3, DATA, SP4, DONE; one char consumed per cycle.
REQ-018 '^' in any state SHALL restart the parse in TIME with all counters and accumulators cleared.
REQ-019 Any character not allowed by the grammar in the current state SHALL go to IDLE; no output is produced for that record.
REQ-020 A digit-count overflow or underflow at a field terminator SHALL go to IDLE.
REQ-021 DONE is entered on the edge that samples the closing '#'.
REQ-022 In DONE, format_type and error_code SHALL be valid for exactly one cycle; they are combinational from registered state.
REQ-023 Outside DONE, format_type=0 and error_code=0.
REQ-024 After DONE, next state follows char: '^' goes to TIME; anything else goes to IDLE.
REQ-025 TIME and GRF SHALL be accumulated in binary (x*10+d); width ceil(log2(10^N)).
REQ-026 PC, ADDR and DATA SHALL be 32-bit shift accumulators.
REQ-027 error bit0 = (time & ((freq>>1)-1)) != 0.
REQ-028 error bit1 = pc[1:0]!=0, or pc<PC_LO, or pc>PC_HI.
REQ-029 error bit2 (format 2 only) = addr[1:0]!=0, or addr<ADDR_LO, or addr>ADDR_HI; 0 for format 1.
REQ-030 error bit3 (format 1 only) = grf>31; 0 for format 2.
REQ-031 Multiple error bits MAY be set simultaneously.
REQ-032 Leading zeros SHALL be legal in TIME and GRF; they count toward the digit limit.

Reset
REQ-033 On reset=1 at a clock edge: state goes to IDLE, all accumulators and counters go to 0, format_type=0, error_code=0.
REQ-034 Reset mid-record SHALL abandon the record; the cycle after reset deasserts SHALL be able to accept '^'.

Structure
REQ-035 State encoding, error-bit indices and format codes SHALL live in shared package cpu_checker_pkg.
REQ-036 Character classification (is_dec, is_hex_lc, hex value) SHALL be one combinational sub-module, char_class.

Verification
REQ-037 freq=2: "^242@000030f4: $31 <= 12345678#" -> format_type=1, error_code=0 for one cycle after '#'.
REQ-038 freq=2: "^338@00003130: *00000088 <= ffffb528#" -> format_type 2, error 0; same with "Ffffb528" -> 0.
REQ-039 Data of 6 or 10 hex digits, or empty data ("<=#") -> format_type=0 throughout.
REQ-040 freq=4: time 243 -> error 4'b0001; pc 00003132 -> 4'b0010; addr 00000089 -> 4'b0100; $32 -> 4'b1000.
REQ-041 '^' injected mid-record, then a valid record -> only the second record reports.
REQ-042 Reset asserted during the DATA field -> outputs 0; next valid record reports normally.
